// File: rtl/mul_hilo_ctrl.sv
// MULT sequencer for the multicycle core: issues low/high product words to the
// shared multiplier, commits HI/LO atomically, serves MTHI/MTLO and a watchdog.
module mul_hilo_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic [31:0] mt_data,
  input  logic        err_clr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        mul_lo_hi,
  output logic        mul_valid_in,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_result,
  input  logic        mul_valid_out
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_LO = 3'd1,
    S_WAIT_LO  = 3'd2,
    S_ISSUE_HI = 3'd3,
    S_WAIT_HI  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] wd_cnt_r;
  logic [31:0]   lo_stage_r;
  logic          idle_s;
  logic          waiting_s;
  logic          timeout_s;
  logic          start_ok_s;
  logic          mt_ok_s;

  // Next-state decode plus acceptance and watchdog qualifiers.
  always_comb begin
    state_nxt_s = state_r;
    idle_s      = (state_r == S_IDLE) || (state_r == S_DONE);
    waiting_s   = (state_r == S_WAIT_LO) || (state_r == S_WAIT_HI);
    timeout_s   = waiting_s && !mul_valid_out && (wd_cnt_r == CW'(TIMEOUT - 1));
    start_ok_s  = idle_s && start;
    mt_ok_s     = idle_s && mt_we && !start;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt_s = S_ISSUE_LO;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE_LO: state_nxt_s = S_WAIT_LO;
      S_WAIT_LO: begin
        if (mul_valid_out) begin
          state_nxt_s = S_ISSUE_HI;
        end else if (timeout_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_WAIT_LO;
        end
      end
      S_ISSUE_HI: state_nxt_s = S_WAIT_HI;
      S_WAIT_HI: begin
        if (mul_valid_out) begin
          state_nxt_s = S_DONE;
        end else if (timeout_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_WAIT_HI;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, registered control outputs, operands, watchdog and HI/LO pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      hi_out       <= 32'd0;
      lo_out       <= 32'd0;
      mul_valid_in <= 1'b0;
      mul_lo_hi    <= 1'b0;
      mul_a        <= 32'd0;
      mul_b        <= 32'd0;
      wd_cnt_r     <= '0;
      lo_stage_r   <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      busy         <= state_nxt_s inside {S_ISSUE_LO, S_WAIT_LO, S_ISSUE_HI, S_WAIT_HI};
      done         <= (state_nxt_s == S_DONE);
      mul_valid_in <= (state_nxt_s == S_ISSUE_LO) || (state_nxt_s == S_ISSUE_HI);
      mul_lo_hi    <= (state_nxt_s == S_ISSUE_HI);

      if (start_ok_s) begin
        mul_a <= op_a;
        mul_b <= op_b;
      end

      // Counter is zero whenever a WAIT state is entered (always from an ISSUE state).
      if (waiting_s && !mul_valid_out) begin
        wd_cnt_r <= wd_cnt_r + CW'(1);
      end else begin
        wd_cnt_r <= '0;
      end

      if ((state_r == S_WAIT_LO) && mul_valid_out) begin
        lo_stage_r <= mul_result;
      end

      if ((state_r == S_WAIT_HI) && mul_valid_out) begin
        hi_out <= mul_result;
        lo_out <= lo_stage_r;
      end else if (mt_ok_s) begin
        if (mt_sel) begin
          hi_out <= mt_data;
        end else begin
          lo_out <= mt_data;
        end
      end

      if (timeout_s) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl: timeline-level model checked every cycle,
// a latency-accurate multiplier stand-in, and hand-computed literal expectations.
module tb_mul_hilo_ctrl;
  localparam int L = 3;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mt_we = 1'b0;
  logic        mt_sel = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] mt_data = 32'd0;
  logic        busy, done, err, mul_lo_hi, mul_valid_in, mul_valid_out;
  logic [31:0] hi_out, lo_out, mul_a, mul_b, mul_result;
  bit          hang = 1'b0;
  bit          spur = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mul_hilo_ctrl #(.MUL_LAT(L), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data), .err_clr(err_clr),
    .busy(busy), .done(done), .err(err), .hi_out(hi_out), .lo_out(lo_out),
    .mul_lo_hi(mul_lo_hi), .mul_valid_in(mul_valid_in), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_valid_out(mul_valid_out)
  );

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  function automatic logic [31:0] prod_word(input logic [31:0] a, input logic [31:0] b, input logic sel);
    logic [63:0] p;
    p = prod(a, b);
    return sel ? p[63:32] : p[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Multiplier stand-in: a result appears exactly L cycles after its issue cycle.
  logic        pv [L];
  logic [31:0] pr [L];
  always @(posedge clk) begin
    pv[0] <= mul_valid_in;
    pr[0] <= prod_word(mul_a, mul_b, mul_lo_hi);
    for (int i = 1; i < L; i++) begin
      pv[i] <= pv[i-1];
      pr[i] <= pr[i-1];
    end
  end
  assign mul_valid_out = (pv[L-1] && !hang) || spur;
  assign mul_result    = pr[L-1];

  // Model: m_t is the cycle index relative to the accepted start (cycle 0), -1 when idle.
  int          m_t;
  bit          m_hang, m_err;
  logic [31:0] m_a, m_b, m_hi, m_lo;

  function automatic bit m_busy(input int t, input bit h);
    return (t >= 1) && (t <= (h ? 1 + T : 2 + 2 * L));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= -1; m_hang <= 1'b0; m_err <= 1'b0;
      m_a <= 32'd0; m_b <= 32'd0; m_hi <= 32'd0; m_lo <= 32'd0;
    end else begin
      if (start && !m_busy(m_t, m_hang)) begin
        m_t <= 1; m_a <= op_a; m_b <= op_b; m_hang <= hang;
      end else if ((m_t >= 1) && (m_t < (m_hang ? 1 + T : 3 + 2 * L))) begin
        m_t <= m_t + 1;
      end else begin
        m_t <= -1;
      end
      if (!m_hang && (m_t == 2 + 2 * L)) begin
        {m_hi, m_lo} <= prod(m_a, m_b);
      end else if (mt_we && !start && !m_busy(m_t, m_hang)) begin
        if (mt_sel) m_hi <= mt_data;
        else        m_lo <= mt_data;
      end
      if (m_hang && (m_t == 1 + T)) m_err <= 1'b1;
      else if (err_clr)             m_err <= 1'b0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_busy(m_t, m_hang));
      chk("done", done, !m_hang && (m_t == 3 + 2 * L));
      chk("err", err, m_err);
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
      chk("mul_valid_in", mul_valid_in, (m_t == 1) || (!m_hang && (m_t == 2 + L)));
      if ((m_t == 1) || (!m_hang && (m_t == 2 + L))) chk("mul_lo_hi", mul_lo_hi, m_t == 2 + L);
      if (m_busy(m_t, m_hang)) begin
        chk("mul_a", mul_a, m_a);
        chk("mul_b", mul_b, m_b);
      end
    end
  end

  task automatic zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_hilo"}, {hi_out, lo_out}, 64'd0);
    chk({tag, "_mulv"}, {mul_valid_in, mul_lo_hi}, 2'b00);
    chk({tag, "_mulab"}, {mul_a, mul_b}, 64'd0);
  endtask

  // Run one MULT; optional mt_we pulse at cycle mt_at and extra start at restart_at.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input int mt_at,
                       input int restart_at, output logic [1:0] lohi);
    int n;
    int k;
    n = 0; k = 0; lohi = 2'b00;
    start = 1'b1; op_a = a; op_b = b; mt_we = (mt_at == 0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = (c == restart_at);
      if (start) begin op_a = 32'd99; op_b = 32'd99; end
      mt_we = (c == mt_at);
      @(negedge clk);
      if (mul_valid_in && (k < 2)) begin lohi[k] = mul_lo_hi; k++; end
      if (done) begin n = c; break; end
    end
    start = 1'b0; mt_we = 1'b0;
    chk("done_latency", n, 9);
  endtask

  initial begin
    logic [1:0] lh;
    int dn;
    int rise;
    #1;
    zero_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    issue(32'd7, 32'hFFFF_FFFD, -1, -1, lh);
    chk("basic_lohi_order", lh, 2'b10);
    chk("basic_hi", hi_out, 32'hFFFF_FFFF);
    chk("basic_lo", lo_out, 32'hFFFF_FFEB);

    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, -1, lh);
    chk("max_hi", hi_out, 32'h3FFF_FFFF);
    chk("max_lo", lo_out, 32'h0000_0001);
    issue(32'h8000_0000, 32'h8000_0000, -1, -1, lh);
    chk("min_hi", hi_out, 32'h4000_0000);
    chk("min_lo", lo_out, 32'h0000_0000);

    mt_sel = 1'b1; mt_data = 32'h1234_5678; mt_we = 1'b1;
    @(posedge clk); #1 mt_we = 1'b0;
    @(negedge clk);
    chk("mthi", hi_out, 32'h1234_5678);
    mt_sel = 1'b0; mt_data = 32'hCAFE_F00D; mt_we = 1'b1;
    @(posedge clk); #1 mt_we = 1'b0;
    @(negedge clk);
    chk("mtlo", {hi_out, lo_out}, 64'h1234_5678_CAFE_F00D);

    mt_sel = 1'b1; mt_data = 32'hDEAD_BEEF;
    issue(32'd5, 32'd6, 3, -1, lh);
    chk("mt_drop", {hi_out, lo_out}, 64'd30);
    mt_sel = 1'b0; mt_data = 32'h1111_1111;
    issue(32'hFFFF_FFFE, 32'd4, 0, -1, lh);
    chk("start_wins", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF8);

    issue(32'd3, 32'd1000, -1, 4, lh);
    chk("busy_start_result", {hi_out, lo_out}, 64'd3000);
    dn = 0;
    repeat (12) begin @(posedge clk); #1; @(negedge clk); if (done) dn++; end
    chk("busy_start_one_done", dn, 0);

    hang = 1'b1; start = 1'b1; op_a = 32'd9; op_b = 32'd9;
    dn = 0; rise = 0;
    for (int c = 1; c <= T + 6; c++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      if (done) dn++;
      if (err && (rise == 0)) rise = c;
    end
    hang = 1'b0;
    chk("wd_err_cycle", rise, 2 + T);
    chk("wd_no_done", dn, 0);
    chk("wd_state", {busy, err}, 2'b01);
    chk("wd_hilo", {hi_out, lo_out}, 64'd3000);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", err, 1'b0);

    spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    @(negedge clk);
    chk("spurious_ignored", {busy, hi_out, lo_out}, {1'b0, 64'd3000});

    start = 1'b1; op_a = 32'd100; op_b = 32'd200;
    for (int c = 1; c <= 7; c++) begin @(posedge clk); #1 start = 1'b0; end
    chk("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1 zero_outputs("midop_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("late_result_ignored", {busy, done, hi_out, lo_out}, 66'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end
endmodule
